// File: rtl/encoder_speed_meter_pkg.sv
// Shared types and defaults for the encoder speed meter.
package encoder_speed_meter_pkg;

    localparam int TICK_W_DEF        = 10;
    localparam int WINDOW_CYCLES_DEF = 50000;
    localparam int AVG_LOG2_DEF      = 2;
    localparam int STALL_WINDOWS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Per-cycle control decoded from the FSM state and inputs.
    typedef struct packed {
        logic clear_all;  // entering PRIME: wipe ring/sum, capture baseline
        logic cnt_en;     // window counter runs
        logic load_prev;  // end of priming window: refresh baseline only
        logic result;     // end of a running window: publish a measurement
    } ctrl_t;

    // Ring pointer width; a single-entry ring still needs a 1-bit pointer.
    function automatic int ptr_width(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/encoder_speed_meter_tick_sync.sv
// Brings the encoder tick count into the clk domain. Three flops of
// synchronisation, then ticks_stable only follows a value that has been
// seen on two consecutive cycles, so multi-bit skew during an update and
// one-cycle glitches never reach the speed arithmetic.
module encoder_speed_meter_tick_sync
    import encoder_speed_meter_pkg::*;
#(
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TICK_W-1:0] ticks_in,
    output logic [TICK_W-1:0] ticks_stable
);

    logic [TICK_W-1:0] s1;
    logic [TICK_W-1:0] s2;
    logic [TICK_W-1:0] s3;

    // Synchroniser chain plus the two-sample agreement filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= '0;
            s2           <= '0;
            s3           <= '0;
            ticks_stable <= '0;
        end else begin
            s1 <= ticks_in;
            s2 <= s1;
            s3 <= s2;
            if (s2 == s3) begin
                ticks_stable <= s2;
            end
        end
    end

endmodule

// File: rtl/encoder_speed_meter.sv
// Turns a free-running encoder tick count into ticks per measurement window,
// raw and moving-averaged, and flags a stalled shaft.
//
// state    | meaning
// ST_IDLE  | disabled; outputs hold, window counter parked at 0
// ST_PRIME | first window after enable; baseline captured, no result
// ST_RUN   | every window end publishes speed_raw/speed_avg/stalled
module encoder_speed_meter
    import encoder_speed_meter_pkg::*;
#(
    parameter int TICK_W        = TICK_W_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int STALL_WINDOWS = STALL_WINDOWS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TICK_W-1:0] ticks_in,
    output logic [TICK_W-1:0] speed_raw,
    output logic [TICK_W-1:0] speed_avg,
    output logic              speed_valid,
    output logic              stalled
);

    localparam int DEPTH   = 1 << AVG_LOG2;
    localparam int PTR_W   = ptr_width(AVG_LOG2);
    localparam int SUM_W   = TICK_W + AVG_LOG2;
    localparam int CNT_W   = $clog2(WINDOW_CYCLES);
    localparam int STALL_W = $clog2(STALL_WINDOWS + 1);

    localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);

    state_t               state;
    state_t               state_nxt;
    ctrl_t                ctrl;

    logic [TICK_W-1:0]    ticks_stable;
    logic [CNT_W-1:0]     win_cnt;
    logic                 win_tc;

    logic [TICK_W-1:0]    prev;
    logic [TICK_W-1:0]    delta;

    logic [TICK_W-1:0]    ring [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_nxt;
    logic [SUM_W-1:0]     avg_full;

    logic [STALL_W-1:0]   stall_cnt;
    logic [STALL_W-1:0]   stall_nxt;

    encoder_speed_meter_tick_sync #(
        .TICK_W (TICK_W)
    ) u_tick_sync (
        .clk          (clk),
        .rst          (rst),
        .ticks_in     (ticks_in),
        .ticks_stable (ticks_stable)
    );

    assign win_tc = (win_cnt == WIN_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; dropping enable always returns to IDLE, even at window end.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (win_tc) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: datapath control strobes, all qualified by enable.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_IDLE: begin
                ctrl.clear_all = enable;
            end
            ST_PRIME: begin
                ctrl.cnt_en    = enable;
                ctrl.load_prev = enable && win_tc;
            end
            ST_RUN: begin
                ctrl.cnt_en = enable;
                ctrl.result = enable && win_tc;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    // Window counter: 0..WINDOW_CYCLES-1, parked at 0 whenever not measuring.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (!ctrl.cnt_en || win_tc) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    // Modular difference keeps the count correct across a counter wrap.
    always_comb begin
        delta      = ticks_stable - prev;
        sum_nxt    = sum - SUM_W'(ring[wr_ptr]) + SUM_W'(delta);
        avg_full   = sum_nxt >> AVG_LOG2;
        wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end

    // Baseline tick count for the window in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (ctrl.clear_all || ctrl.load_prev || ctrl.result) begin
            prev <= ticks_stable;
        end
    end

    // Moving-average ring and running sum; the sum is wide enough for DEPTH full-scale deltas.
    always_ff @(posedge clk) begin
        if (rst || ctrl.clear_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            sum    <= '0;
            wr_ptr <= '0;
        end else if (ctrl.result) begin
            ring[wr_ptr] <= delta;
            sum          <= sum_nxt;
            wr_ptr       <= wr_ptr_nxt;
        end
    end

    // Consecutive zero-delta windows, saturating at the stall threshold.
    always_comb begin
        if (delta != '0) begin
            stall_nxt = '0;
        end else if (stall_cnt == STALL_MAX) begin
            stall_nxt = stall_cnt;
        end else begin
            stall_nxt = stall_cnt + 1'b1;
        end
    end

    // Stall counter is deliberately kept across re-priming.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (ctrl.result) begin
            stall_cnt <= stall_nxt;
        end
    end

    // Output registers: update the cycle after a running window ends, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_raw   <= '0;
            speed_avg   <= '0;
            speed_valid <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            speed_valid <= ctrl.result;
            if (ctrl.result) begin
                speed_raw <= delta;
                speed_avg <= avg_full[TICK_W-1:0];
                stalled   <= (stall_nxt == STALL_MAX);
            end
        end
    end

endmodule

// File: tb/tb_encoder_speed_meter.sv
// Directed bench for encoder_speed_meter with a 100-cycle window,
// 4-deep average and a 3-window stall threshold.
module tb_encoder_speed_meter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [9:0] ticks_in;
    logic [9:0] speed_raw;
    logic [9:0] speed_avg;
    logic       speed_valid;
    logic       stalled;

    int errors = 0;
    int checks = 0;

    // Tick generator configuration, written only by the main sequence.
    logic [9:0] cfg_base   = '0;
    int         cfg_period = 0;
    int         cfg_step   = 0;
    int         cfg_stamp  = 0;
    logic       glitch_on  = 1'b0;

    encoder_speed_meter #(
        .TICK_W        (10),
        .WINDOW_CYCLES (100),
        .AVG_LOG2      (2),
        .STALL_WINDOWS (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ticks_in    (ticks_in),
        .speed_raw   (speed_raw),
        .speed_avg   (speed_avg),
        .speed_valid (speed_valid),
        .stalled     (stalled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Encoder model: drives ticks_in 1 time unit after each rising edge.
    initial begin
        logic [9:0] tick_cur;
        int         phase;
        int         seen_stamp;
        logic       flip;
        tick_cur   = '0;
        phase      = 0;
        seen_stamp = 0;
        flip       = 1'b0;
        ticks_in   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cfg_stamp != seen_stamp) begin
                seen_stamp = cfg_stamp;
                tick_cur   = cfg_base;
                phase      = 0;
            end else if (cfg_period != 0) begin
                phase++;
                if (phase >= cfg_period) begin
                    phase    = 0;
                    tick_cur = tick_cur + 10'(cfg_step);
                end
            end
            if (glitch_on) begin
                flip     = !flip;
                ticks_in = flip ? 10'h155 : 10'h0AA;
            end else begin
                ticks_in = tick_cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!speed_valid && n < limit);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        cfg_base   = 10'd0;
        cfg_period = 10;
        cfg_step   = 1;
        cfg_stamp++;
        repeat (3) @(negedge clk);
        checks++; if (speed_raw !== 10'd0) begin errors++; $display("FAIL reset_raw: got %0d expected 0", speed_raw); end
        checks++; if (speed_avg !== 10'd0) begin errors++; $display("FAIL reset_avg: got %0d expected 0", speed_avg); end
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", speed_valid); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %0d expected 0", stalled); end
    endtask

    task automatic test_steady_rate();
        int exp_avg [5] = '{2, 5, 7, 10, 10};
        int n;
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(300, n);
            checks++; if (n != ((i == 0) ? 201 : 100)) begin errors++; $display("FAIL steady_latency[%0d]: got %0d cycles expected %0d", i, n, (i == 0) ? 201 : 100); end
            checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL steady_raw[%0d]: got %0d expected 10", i, speed_raw); end
            checks++; if (speed_avg !== 10'(exp_avg[i])) begin errors++; $display("FAIL steady_avg[%0d]: got %0d expected %0d", i, speed_avg, exp_avg[i]); end
            checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL steady_stalled[%0d]: got %0d expected 0", i, stalled); end
        end
    endtask

    task automatic test_enable_at_tc();
        int seen;
        @(negedge clk);
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %0d expected 0", speed_valid); end
        repeat (98) @(negedge clk);
        enable = 1'b0;
        seen   = 0;
        repeat (5) begin
            @(negedge clk);
            if (speed_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL enable_tc_valid: got %0d strobes expected 0", seen); end
        checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL enable_tc_raw_hold: got %0d expected 10", speed_raw); end
        checks++; if (speed_avg !== 10'd10) begin errors++; $display("FAIL enable_tc_avg_hold: got %0d expected 10", speed_avg); end
    endtask

    task automatic test_reenable();
        int exp_avg [3] = '{2, 5, 7};
        int n;
        int seen;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(300, n);
            checks++; if (n != ((i == 0) ? 201 : 100)) begin errors++; $display("FAIL reen_latency[%0d]: got %0d cycles expected %0d", i, n, (i == 0) ? 201 : 100); end
            checks++; if (speed_avg !== 10'(exp_avg[i])) begin errors++; $display("FAIL reen_avg[%0d]: got %0d expected %0d", i, speed_avg, exp_avg[i]); end
        end
        repeat (50) @(negedge clk);
        enable = 1'b0;
        seen   = 0;
        repeat (20) begin
            @(negedge clk);
            if (speed_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reen_idle_valid: got %0d strobes expected 0", seen); end
        checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL reen_raw_hold: got %0d expected 10", speed_raw); end
        checks++; if (speed_avg !== 10'd7) begin errors++; $display("FAIL reen_avg_hold: got %0d expected 7", speed_avg); end
        enable = 1'b1;
        wait_valid(300, n);
        checks++; if (n != 201) begin errors++; $display("FAIL reen_reprime_latency: got %0d cycles expected 201", n); end
        checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL reen_reprime_raw: got %0d expected 10", speed_raw); end
        checks++; if (speed_avg !== 10'd2) begin errors++; $display("FAIL reen_reprime_avg: got %0d expected 2", speed_avg); end
    endtask

    task automatic test_mid_reset();
        int n;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (speed_raw !== 10'd0) begin errors++; $display("FAIL midrst_raw: got %0d expected 0", speed_raw); end
        checks++; if (speed_avg !== 10'd0) begin errors++; $display("FAIL midrst_avg: got %0d expected 0", speed_avg); end
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0d expected 0", speed_valid); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL midrst_stalled: got %0d expected 0", stalled); end
        rst = 1'b0;
        wait_valid(300, n);
        checks++; if (n != 201) begin errors++; $display("FAIL midrst_latency: got %0d cycles expected 201", n); end
        checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL midrst_raw_after: got %0d expected 10", speed_raw); end
        checks++; if (speed_avg !== 10'd2) begin errors++; $display("FAIL midrst_avg_after: got %0d expected 2", speed_avg); end
    endtask

    task automatic test_wrap();
        int exp_avg [5] = '{2, 5, 7, 10, 10};
        int n;
        enable     = 1'b0;
        cfg_base   = 10'd995;
        cfg_period = 100;
        cfg_step   = 10;
        cfg_stamp++;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(300, n);
            checks++; if (n != ((i == 0) ? 201 : 100)) begin errors++; $display("FAIL wrap_latency[%0d]: got %0d cycles expected %0d", i, n, (i == 0) ? 201 : 100); end
            checks++; if (speed_raw !== 10'd10) begin errors++; $display("FAIL wrap_raw[%0d]: got %0d expected 10", i, speed_raw); end
            checks++; if (speed_avg !== 10'(exp_avg[i])) begin errors++; $display("FAIL wrap_avg[%0d]: got %0d expected %0d", i, speed_avg, exp_avg[i]); end
        end
    endtask

    task automatic test_stall();
        logic exp_stall [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int n;
        enable     = 1'b0;
        cfg_base   = 10'd500;
        cfg_period = 0;
        cfg_stamp++;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(300, n);
            checks++; if (n != ((i == 0) ? 201 : 100)) begin errors++; $display("FAIL stall_latency[%0d]: got %0d cycles expected %0d", i, n, (i == 0) ? 201 : 100); end
            checks++; if (speed_raw !== 10'd0) begin errors++; $display("FAIL stall_raw[%0d]: got %0d expected 0", i, speed_raw); end
            checks++; if (stalled !== exp_stall[i]) begin errors++; $display("FAIL stall_flag[%0d]: got %0d expected %0d", i, stalled, exp_stall[i]); end
        end
        cfg_base = 10'd503;
        cfg_stamp++;
        wait_valid(300, n);
        checks++; if (n != 100) begin errors++; $display("FAIL unstall_latency: got %0d cycles expected 100", n); end
        checks++; if (speed_raw !== 10'd3) begin errors++; $display("FAIL unstall_raw: got %0d expected 3", speed_raw); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL unstall_flag: got %0d expected 0", stalled); end
        checks++; if (speed_avg !== 10'd0) begin errors++; $display("FAIL unstall_avg: got %0d expected 0", speed_avg); end
    endtask

    task automatic test_glitch();
        int n;
        int seen;
        int raw_seen;
        repeat (30) @(negedge clk);
        glitch_on = 1'b1;
        @(negedge clk);
        glitch_on = 1'b0;
        wait_valid(300, n);
        checks++; if (n != 69) begin errors++; $display("FAIL glitch_latency: got %0d cycles expected 69", n); end
        checks++; if (speed_raw !== 10'd0) begin errors++; $display("FAIL glitch_raw: got %0d expected 0", speed_raw); end
        repeat (90) @(negedge clk);
        glitch_on = 1'b1;
        seen      = 0;
        raw_seen  = -1;
        repeat (20) begin
            @(negedge clk);
            if (speed_valid) begin
                seen++;
                raw_seen = int'(speed_raw);
            end
        end
        glitch_on = 1'b0;
        checks++; if (seen != 1) begin errors++; $display("FAIL burst_valid_count: got %0d expected 1", seen); end
        checks++; if (raw_seen != 0) begin errors++; $display("FAIL burst_raw: got %0d expected 0", raw_seen); end
        wait_valid(300, n);
        checks++; if (n != 90) begin errors++; $display("FAIL post_burst_latency: got %0d cycles expected 90", n); end
        checks++; if (speed_raw !== 10'd0) begin errors++; $display("FAIL post_burst_raw: got %0d expected 0", speed_raw); end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL post_burst_stalled: got %0d expected 1", stalled); end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        test_reset();
        test_steady_rate();
        test_enable_at_tc();
        test_reenable();
        test_mid_reset();
        test_wrap();
        test_stall();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
